// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   kp_state_t  - debounce FSM states
//   frame_res_t - classification of one full scan frame
//   clog2       - width helper, minimum 1 bit
//   key_legend  - ASCII legend for a standard 4x4 pad, indexed by linear
//                 key code (code = col*4 + row), for downstream display use
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} kp_state_t;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_t;

  function automatic int unsigned clog2(input int unsigned value);
    clog2 = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) clog2 = i + 1;
    end
  endfunction

  localparam logic [7:0] KEY_LEGEND [16] = '{
    "1", "4", "7", "*",
    "2", "5", "8", "0",
    "3", "6", "9", "#",
    "A", "B", "C", "D"
  };

  function automatic logic [7:0] key_legend(input logic [3:0] code);
    return KEY_LEGEND[code];
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column strobe generator for the keypad scanner.
//   clk_100MHz  in   system clock
//   rst_n       in   asynchronous active-low reset
//   col         out  one-cold column drive (column c drives col[NUM_COLS-1-c])
//   col_idx     out  index of the column currently driven
//   sample_stb  out  high for the one cycle of each slot when rows are sampled
//   frame_end   out  high on the last cycle of the last column slot
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter  int unsigned NUM_COLS   = 4,
  parameter  int unsigned SCAN_TICKS = 100000,
  parameter  int unsigned SETTLE     = 10,
  localparam int unsigned CW         = clog2(NUM_COLS)
) (
  input  logic                clk_100MHz,
  input  logic                rst_n,
  output logic [NUM_COLS-1:0] col,
  output logic [CW-1:0]       col_idx,
  output logic                sample_stb,
  output logic                frame_end
);

  localparam int unsigned          TW        = clog2(SCAN_TICKS);
  localparam logic [TW-1:0]        TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0]        TICK_SMPL = TW'(SETTLE);
  localparam logic [CW-1:0]        COL_LAST  = CW'(NUM_COLS - 1);
  localparam logic [NUM_COLS-1:0]  COL_RST   = {1'b0, {(NUM_COLS-1){1'b1}}};

  logic [TW-1:0]       timer;
  logic                wrap;
  logic [CW-1:0]       idx_nxt;
  logic [NUM_COLS-1:0] col_nxt;

  assign wrap       = (timer == TICK_LAST);
  assign sample_stb = (timer == TICK_SMPL);
  assign frame_end  = wrap && (col_idx == COL_LAST);
  assign idx_nxt    = (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);

  // Column drive is precomputed from the next index so the registered
  // strobe lines up with col_idx on the cycle after the wrap.
  always_comb begin
    col_nxt = '1;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (idx_nxt == CW'(c)) col_nxt[NUM_COLS-1-c] = 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      col_idx <= '0;
      col     <= COL_RST;
    end else if (wrap) begin
      timer   <= '0;
      col_idx <= idx_nxt;
      col     <= col_nxt;
    end else begin
      timer   <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with per-key debounce, press/release
// events and multi-key rejection.
//   clk_100MHz   in   system clock
//   rst_n        in   asynchronous active-low reset
//   row          in   row sense, active-low, externally pulled up
//   col          out  column drive, one-cold
//   key_code     out  last accepted key (col*NUM_ROWS + row), held
//   key_valid    out  one-cycle pulse on accepted press (or auto-repeat)
//   key_held     out  high from press accept until release accept
//   key_release  out  one-cycle pulse when a release is accepted
//   multi_key    out  high while the last frame saw more than one key
// Build option: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid while a
// key is held (after REPEAT_DELAY frames, then every REPEAT_RATE frames).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int unsigned NUM_ROWS       = 4,
  parameter  int unsigned NUM_COLS       = 4,
  parameter  int unsigned SCAN_TICKS     = 100000,
  parameter  int unsigned SETTLE         = 10,
  parameter  int unsigned DEBOUNCE_SCANS = 4,
  parameter  int unsigned REPEAT_DELAY   = 500,
  parameter  int unsigned REPEAT_RATE    = 100,
  localparam int unsigned KEY_W          = clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk_100MHz,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_release,
  output logic                multi_key
);

  localparam int unsigned   CW      = clog2(NUM_COLS);
  localparam int unsigned   DW      = clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS);

  logic [CW-1:0] col_idx;
  logic          sample_stb;
  logic          frame_end;

  keypad_col_scan #(
    .NUM_COLS   (NUM_COLS),
    .SCAN_TICKS (SCAN_TICKS),
    .SETTLE     (SETTLE)
  ) u_col_scan (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .col        (col),
    .col_idx    (col_idx),
    .sample_stb (sample_stb),
    .frame_end  (frame_end)
  );

  // Frame accumulators: saturating hit count and code of the first hit.
  logic [1:0]       hit_cnt, slot_cnt;
  logic [KEY_W-1:0] first_code, slot_code;
  frame_res_t       res;

  always_comb begin
    slot_cnt  = hit_cnt;
    slot_code = first_code;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!row[NUM_ROWS-1-r]) begin
        if (slot_cnt == 2'd0) slot_code = KEY_W'(32'(col_idx) * NUM_ROWS + r);
        if (slot_cnt != 2'd2) slot_cnt = slot_cnt + 2'd1;
      end
    end
  end

  assign res = (hit_cnt == 2'd0) ? NONE : (hit_cnt == 2'd1) ? SINGLE : MULTI;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt    <= '0;
      first_code <= '0;
    end else if (frame_end) begin
      hit_cnt    <= '0;
      first_code <= '0;
    end else if (sample_stb) begin
      hit_cnt    <= slot_cnt;
      first_code <= slot_code;
    end
  end

  // Debounce FSM, advanced only on frame_end.
  kp_state_t        state, state_nxt;
  logic [KEY_W-1:0] cand, cand_nxt, code_nxt;
  logic [DW-1:0]    cnt, cnt_nxt;
  logic             valid_nxt, release_nxt, held_nxt, multi_nxt;
  logic             same;

  assign same = (res == SINGLE) && (first_code == cand);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [RW-1:0] rep_cnt, rep_cnt_nxt;
  logic          rep_armed, rep_armed_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    code_nxt    = key_code;
    valid_nxt   = 1'b0;
    release_nxt = 1'b0;
    held_nxt    = key_held;
    multi_nxt   = multi_key;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nxt   = rep_cnt;
    rep_armed_nxt = rep_armed;
`endif
    if (frame_end) begin
      multi_nxt = (res == MULTI);
      unique case (state)
        IDLE: begin
          if (res == SINGLE) begin
            cand_nxt  = first_code;
            cnt_nxt   = DW'(1);
            state_nxt = DB_PRESS;
            if (DB_LAST == DW'(1)) begin
              state_nxt = HELD;
              code_nxt  = first_code;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
            end
          end
        end
        DB_PRESS: begin
          if (same) begin
            cnt_nxt = cnt + DW'(1);
            if (cnt_nxt == DB_LAST) begin
              state_nxt = HELD;
              code_nxt  = cand;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
            end
          end else if (res == SINGLE) begin
            cand_nxt = first_code;
            cnt_nxt  = DW'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: begin
          if (!same && (res != MULTI)) begin
            cnt_nxt   = DW'(1);
            state_nxt = DB_REL;
            if (DB_LAST == DW'(1)) begin
              state_nxt   = IDLE;
              release_nxt = 1'b1;
              held_nxt    = 1'b0;
            end
          end
        end
        DB_REL: begin
          if (same || (res == MULTI)) begin
            state_nxt = HELD;
          end else begin
            cnt_nxt = cnt + DW'(1);
            if (cnt_nxt == DB_LAST) begin
              state_nxt   = IDLE;
              release_nxt = 1'b1;
              held_nxt    = 1'b0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
`ifdef KEYPAD_AUTOREPEAT_EN
      // Repeat timing restarts whenever HELD is entered (including a return
      // from DB_REL) and does not advance on multi-key frames.
      if ((state != HELD) || (state_nxt != HELD)) begin
        rep_cnt_nxt   = '0;
        rep_armed_nxt = 1'b0;
      end else if (res != MULTI) begin
        rep_cnt_nxt = rep_cnt + RW'(1);
        if (!rep_armed && (rep_cnt_nxt == RW'(REPEAT_DELAY))) begin
          valid_nxt     = 1'b1;
          rep_cnt_nxt   = '0;
          rep_armed_nxt = 1'b1;
        end else if (rep_armed && (rep_cnt_nxt == RW'(REPEAT_RATE))) begin
          valid_nxt   = 1'b1;
          rep_cnt_nxt = '0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      multi_key   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt     <= '0;
      rep_armed   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      key_code    <= code_nxt;
      key_valid   <= valid_nxt;
      key_release <= release_nxt;
      key_held    <= held_nxt;
      multi_key   <= multi_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt     <= rep_cnt_nxt;
      rep_armed   <= rep_armed_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner (4x4, 20-tick
// slots, sample offset 2, 3-frame debounce). A behavioural keypad pulls
// rows low for pressed keys on the currently driven column; expected
// press/release events are queued ahead of the frames that should produce
// them and matched by a monitor against every pulse the scanner emits.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int unsigned NR    = 4;
  localparam int unsigned NC    = 4;
  localparam int unsigned ST    = 20;
  localparam int unsigned FRAME = NC * ST;

  logic          clk_100MHz = 1'b0;
  logic          rst_n;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic [3:0]    key_code;
  logic          key_valid, key_held, key_release, multi_key;
  logic [15:0]   keys;

  always #5 clk_100MHz = ~clk_100MHz;

  keypad_scanner #(
    .NUM_ROWS       (NR),
    .NUM_COLS       (NC),
    .SCAN_TICKS     (ST),
    .SETTLE         (2),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release),
    .multi_key   (multi_key)
  );

  // Physical keypad: key c*NR+r shorts column line NC-1-c to row line NR-1-r.
  always_comb begin
    row = '1;
    for (int c = 0; c < NC; c++)
      if (!col[NC-1-c])
        for (int r = 0; r < NR; r++)
          if (keys[c*NR+r]) row[NR-1-r] = 1'b0;
  end

  typedef struct packed {
    logic       is_rel;
    logic [3:0] code;
  } evt_t;

  evt_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every pulse must match the head of the expectation queue.
  always @(negedge clk_100MHz) begin
    evt_t e;
    if (key_valid || key_release) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_pulse", 32'({key_valid, key_release}), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check_val("pulse_kind", 32'({key_valid, key_release}), 32'(e.is_rel ? 2'b01 : 2'b10));
        check_val("pulse_code", 32'(key_code), 32'(e.code));
      end
    end
  end

  function automatic logic [15:0] k(input int unsigned i);
    return 16'd1 << i;
  endfunction

  task automatic expect_evt(input logic is_rel, input logic [3:0] code);
    evt_t e;
    e.is_rel = is_rel;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  // Hold a key pattern for n full frames; returns just after the last frame
  // end so registered outputs (and any pulse) reflect that frame.
  task automatic frames(input int unsigned n, input logic [15:0] mask);
    keys = mask;
    repeat (n * FRAME) @(negedge clk_100MHz);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_col"},     32'(col),         32'(4'b0111));
    check_val({tag, "_code"},    32'(key_code),    32'(0));
    check_val({tag, "_valid"},   32'(key_valid),   32'(0));
    check_val({tag, "_held"},    32'(key_held),    32'(0));
    check_val({tag, "_release"}, 32'(key_release), 32'(0));
    check_val({tag, "_multi"},   32'(multi_key),   32'(0));
  endtask

  task automatic check_pending(input string tag);
    check_val(tag, 32'(exp_q.size()), 32'(0));
  endtask

  logic [3:0] col_seq [4];

  initial begin
    col_seq = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
    rst_n = 1'b1;
    keys  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Column strobe sequence over the first (empty) frame.
    for (int i = 0; i < 4; i++) begin
      repeat (ST) @(negedge clk_100MHz);
      check_val("col_step", 32'(col), 32'(col_seq[i]));
    end
    #2;

    // Clean press of key 9, accepted on the 3rd frame.
    frames(2, k(9));
    check_val("p9_early_held", 32'(key_held), 32'(0));
    expect_evt(1'b0, 4'd9);
    frames(1, k(9));
    check_val("p9_held", 32'(key_held), 32'(1));
    check_val("p9_code", 32'(key_code), 32'(9));
    check_pending("p9_pending");

    // Release with one stray frame of key 9, then a clean release.
    frames(2, '0);
    check_val("r9_dbrel_held", 32'(key_held), 32'(1));
    frames(1, k(9));
    check_val("r9_stray_held", 32'(key_held), 32'(1));
    frames(2, '0);
    check_val("r9_early_held", 32'(key_held), 32'(1));
    expect_evt(1'b1, 4'd9);
    frames(1, '0);
    check_val("r9_held", 32'(key_held), 32'(0));
    check_val("r9_code", 32'(key_code), 32'(9));
    check_pending("r9_pending");

    // Bouncing press: 2 frames, gap, then 3 frames.
    frames(2, k(9));
    frames(1, '0);
    frames(2, k(9));
    check_val("b9_early_held", 32'(key_held), 32'(0));
    expect_evt(1'b0, 4'd9);
    frames(1, k(9));
    check_val("b9_held", 32'(key_held), 32'(1));
    expect_evt(1'b1, 4'd9);
    frames(3, '0);
    check_val("b9_rel_held", 32'(key_held), 32'(0));
    check_pending("b9_pending");

    // Keys 0 and 5 together: multi-key, no event; then key 0 alone.
    frames(1, k(0) | k(5));
    check_val("m05_multi1", 32'(multi_key), 32'(1));
    frames(4, k(0) | k(5));
    check_val("m05_multi5", 32'(multi_key), 32'(1));
    check_val("m05_held",   32'(key_held),  32'(0));
    frames(2, k(0));
    check_val("m0_multi",      32'(multi_key), 32'(0));
    check_val("m0_early_held", 32'(key_held),  32'(0));
    expect_evt(1'b0, 4'd0);
    frames(1, k(0));
    check_val("m0_code", 32'(key_code), 32'(0));
    check_val("m0_held", 32'(key_held), 32'(1));
    // Rollover while held is ignored.
    frames(2, k(0) | k(5));
    check_val("roll_held",  32'(key_held),  32'(1));
    check_val("roll_multi", 32'(multi_key), 32'(1));
    expect_evt(1'b1, 4'd0);
    frames(3, '0);
    check_val("m0_rel_held",  32'(key_held),  32'(0));
    check_val("m0_rel_multi", 32'(multi_key), 32'(0));
    check_pending("m0_pending");

    // Last column, last row.
    frames(2, k(15));
    expect_evt(1'b0, 4'd15);
    frames(1, k(15));
    check_val("k15_code", 32'(key_code), 32'(15));
    expect_evt(1'b1, 4'd15);
    frames(3, '0);
    check_pending("k15_pending");

    // Reset in the middle of a press debounce.
    frames(2, k(9));
    #23 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    keys = '0;
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    frames(4, '0);
    check_val("post_rst_held", 32'(key_held), 32'(0));
    check_val("post_rst_code", 32'(key_code), 32'(0));
    frames(2, k(9));
    check_val("post_rst_early", 32'(key_held), 32'(0));
    expect_evt(1'b0, 4'd9);
    frames(1, k(9));
    check_val("post_rst_held9", 32'(key_held), 32'(1));
    expect_evt(1'b1, 4'd9);
    frames(3, '0);

    check_pending("final_pending");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
